// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx -- parallel-in serial-out transmitter with a one-word holding buffer
//
// Takes WIDTH-bit words over a valid/ready load handshake and sends them one
// bit per clock on q_out. A one-word holding register lets the next word be
// accepted while the current one is still shifting, so words stream with no
// gap cycles.
//
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both high. load_ready depends only on registered state
// (holding buffer empty); there is no path from load_valid to load_ready.
// din is sampled only on that transfer edge.
//
// Parameters:
//   WIDTH      bits per word (2 or more)
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   din         in   parallel word to send
//   load_valid  in   din holds a word to send
//   load_ready  out  holding buffer empty, a word can be accepted
//   q_out       out  serial data bit (registered)
//   frame       out  q_out carries a valid data bit (registered)
//   last        out  q_out carries the final bit of a word (registered)
// ---------------------------------------------------------------------------
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q_out,
  output logic             frame,
  output logic             last
);

  localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] hold_nxt;
  logic             hold_full;
  logic             hold_full_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             q_nxt;
  logic             frame_nxt;
  logic             last_nxt;
  logic             xfer;
  logic             at_last;

  // Move the shift register one position toward the output end.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) r = {v[WIDTH-2:0], 1'b0};
    else           r = {1'b0, v[WIDTH-1:1]};
    return r;
  endfunction

  // Bit of the shift register that is presented on q_out.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    logic r;
    if (MSB_FIRST) r = v[WIDTH-1];
    else           r = v[0];
    return r;
  endfunction

  assign load_ready = ~hold_full;
  assign xfer       = load_valid & ~hold_full;
  assign at_last    = (cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic. The outputs are computed from the next-state values so
  // that q_out/frame/last are true registers yet line up with the state they
  // describe (first bit appears right after the transfer edge).
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    sh_nxt        = sh;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    cnt_nxt       = cnt;

    case (state)
      IDLE: begin
        if (xfer) begin
          sh_nxt    = din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (at_last) begin
          // End of a word. A held word has priority; hold_full implies
          // load_ready is low, so xfer cannot also be true here.
          cnt_nxt = '0;
          if (hold_full) begin
            sh_nxt        = hold;
            hold_full_nxt = 1'b0;
          end else if (xfer) begin
            // Seamless load straight into the shifter, bypassing hold.
            sh_nxt = din;
          end else begin
            sh_nxt    = '0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
          sh_nxt  = shift_one(sh);
          if (xfer) begin
            hold_nxt      = din;
            hold_full_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    frame_nxt = (state_nxt == SHIFT);
    q_nxt     = frame_nxt & out_bit(sh_nxt);
    last_nxt  = frame_nxt & (cnt_nxt == CNT_LAST);
  end

  // -------------------------------------------------------------------------
  // State and output registers. Reset discards both the in-flight and the
  // held word and clears the outputs without waiting for a clock edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      q_out     <= 1'b0;
      frame     <= 1'b0;
      last      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      cnt       <= cnt_nxt;
      q_out     <= q_nxt;
      frame     <= frame_nxt;
      last      <= last_nxt;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx -- bench for piso_tx. Two instances (MSB-first and LSB-first)
// share the same load stimulus. Every accepted word pushes its expected bit
// sequence into a per-instance queue; a monitor on the falling edge pops and
// compares whenever frame is high.
// ---------------------------------------------------------------------------
module tb_piso_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;

  logic ready_m, q_m, frame_m, last_m;
  logic ready_l, q_l, frame_l, last_l;

  int errors = 0;
  int checks = 0;

  // Expected {last, q_out} per bit, in send order.
  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];
  logic [1:0] em;
  logic [1:0] el;

  int           acc_cnt    = 0;
  int           last_cnt_m = 0;
  int           last_cnt_l = 0;
  logic [W-1:0] last_acc   = '0;
  int           run        = 0;
  int           last_run   = 0;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(ready_m), .q_out(q_m), .frame(frame_m), .last(last_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(ready_l), .q_out(q_l), .frame(frame_l), .last(last_l)
  );

  // ---- clock --------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- check helper -------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- acceptance: push expected bits for each handshake --------------------
  always @(posedge clk) begin
    if (rst_n && load_valid && ready_m) begin
      acc_cnt++;
      last_acc = din;
      for (int i = W - 1; i >= 0; i--) exp_m.push_back({(i == 0), din[i]});
      for (int i = 0; i < W; i++)      exp_l.push_back({(i == W - 1), din[i]});
    end
  end

  // ---- monitor ------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_m) begin
        if (last_m) last_cnt_m++;
        if (exp_m.size() == 0) check("msb_unexpected_bit", 1, 0);
        else begin
          em = exp_m.pop_front();
          check("msb_bit", {last_m, q_m}, em);
        end
      end else begin
        check("msb_idle_outputs", {last_m, q_m}, 2'b00);
      end

      if (frame_l) begin
        if (last_l) last_cnt_l++;
        if (exp_l.size() == 0) check("lsb_unexpected_bit", 1, 0);
        else begin
          el = exp_l.pop_front();
          check("lsb_bit", {last_l, q_l}, el);
        end
      end else begin
        check("lsb_idle_outputs", {last_l, q_l}, 2'b00);
      end

      if (frame_m) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  // ---- driver tasks (called at a falling edge) ------------------------------
  task automatic wait_ready();
    int n = 0;
    while (!ready_m && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_m) check("ready_timeout", 0, 1);
  endtask

  // Present a word and return at the falling edge after it transfers;
  // load_valid stays high so the caller can stream.
  task automatic send(input logic [W-1:0] w);
    din        = w;
    load_valid = 1'b1;
    wait_ready();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    load_valid = 1'b0;
    while ((exp_m.size() != 0 || exp_l.size() != 0 || frame_m || frame_l) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // ---- stimulus -----------------------------------------------------------
  initial begin
    int i;
    int acc0;

    // Reset state
    #3;
    check("rst_q_m", q_m, 1'b0);
    check("rst_frame_m", frame_m, 1'b0);
    check("rst_last_m", last_m, 1'b0);
    check("rst_ready_m", ready_m, 1'b1);
    check("rst_q_l", q_l, 1'b0);
    check("rst_frame_l", frame_l, 1'b0);
    check("rst_last_l", last_l, 1'b0);
    check("rst_ready_l", ready_l, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word: MSB-first 1,0,1,0,0,1,0,1 and exactly 8 frame cycles
    send(8'hA5);
    drain();
    check("single_frame_len", last_run, 8);

    // LSB-first: 8'h01 gives 1 then seven 0s on the LSB instance
    send(8'h01);
    drain();
    check("lsb_frame_len", last_run, 8);

    // Back-to-back: three words with load_valid held high
    send(8'hF0);
    send(8'h0F);
    check("b2b_ready_low_m", ready_m, 1'b0);
    check("b2b_ready_low_l", ready_l, 1'b0);
    send(8'hAA);
    drain();
    check("b2b_frame_len", last_run, 24);

    // Seamless load on the edge that ends the last bit of 8'hC3
    send(8'hC3);
    load_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("seam_ready_m", ready_m, 1'b1);
    send(8'h3C);
    drain();
    check("seam_frame_len", last_run, 16);

    // Backpressure: din changes every cycle while load_ready is low;
    // 8'h11 transfers at edge N, 8'h22 at N+1 into hold, ready returns
    // after N+8, so the value last driven (8'h46) is the one sent.
    acc0 = acc_cnt;
    send(8'h11);
    send(8'h22);
    i = 0;
    do begin
      din = 8'h40 + W'(i);
      i++;
      @(negedge clk);
    end while (!ready_m && i < 50);
    @(negedge clk);
    load_valid = 1'b0;
    drain();
    check("bp_accepted_word", last_acc, 8'h46);
    check("bp_handshakes", acc_cnt - acc0, 3);
    check("word_count_m", last_cnt_m, acc_cnt);
    check("word_count_l", last_cnt_l, acc_cnt);

    // Reset mid-word: 8'hA5 shifting, 8'h55 in hold
    send(8'hA5);
    send(8'h55);
    load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_frame_m", frame_m, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_m.delete();
    exp_l.delete();
    #1;
    check("mid_rst_q_m", q_m, 1'b0);
    check("mid_rst_frame_m", frame_m, 1'b0);
    check("mid_rst_last_m", last_m, 1'b0);
    check("mid_rst_ready_m", ready_m, 1'b1);
    check("mid_rst_frame_l", frame_l, 1'b0);
    check("mid_rst_ready_l", ready_l, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_rst_frame_m", frame_m, 1'b0);
      check("post_rst_frame_l", frame_l, 1'b0);
    end
    check("post_rst_queue_m", exp_m.size(), 0);
    check("post_rst_queue_l", exp_l.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
